trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 136 +++++++++++++
 tb/tb_trap_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry/return sequencer: drains the bus, redirects the PC, strobes the CSR file.
// Optional TRAP_SEQUENCER_WFI_EN enables the WFI sleep state.
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception,
  input  logic [30:0] exception_cause,
  input  logic        interrupted,
  input  logic        mret,
  input  logic        wfi,
  input  logic        mem_busy,
  input  logic [31:0] trap_pc,
  input  logic [31:0] ret_pc,
  output logic        handle_trap,
  output logic        exit_trap,
  output logic        trap_exception,
  output logic [30:0] trap_cause,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        halted
);

  localparam int CW = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {RUN, DRAIN, TRAP, RET, WFI, HALT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          take_trap;
  logic          trap_is_exc;
  logic          wfi_req;

`ifdef TRAP_SEQUENCER_WFI_EN
  assign wfi_req = wfi;
`else
  logic unused_wfi;
  assign wfi_req    = 1'b0;
  assign unused_wfi = wfi;
`endif

  // Redirect targets are word aligned; the low address bits are dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{trap_pc[1:0], ret_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= '0;
      trap_exception <= 1'b0;
      trap_cause     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (take_trap) begin
        trap_exception <= trap_is_exc;
        trap_cause     <= trap_is_exc ? exception_cause : 31'd0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    take_trap   = 1'b0;
    trap_is_exc = 1'b0;
    handle_trap = 1'b0;
    exit_trap   = 1'b0;
    stall       = 1'b1;
    pc_load     = 1'b0;
    pc_next     = 32'd0;
    halted      = 1'b0;

    case (state)
      RUN: begin
        stall = exception | interrupted | mret | wfi_req;
        if (exception) begin
          take_trap   = 1'b1;
          trap_is_exc = 1'b1;
        end else if (interrupted) begin
          take_trap = 1'b1;
        end else if (mret) begin
          state_next = RET;
        end else if (wfi_req) begin
          state_next = WFI;
        end
      end
      WFI: begin
`ifdef TRAP_SEQUENCER_WFI_EN
        if (interrupted) take_trap = 1'b1;
`else
        state_next = RUN;
`endif
      end
      DRAIN: begin
        if (!mem_busy) begin
          state_next = TRAP;
          cnt_next   = '0;
        end else if ((DRAIN_TIMEOUT > 0) && (cnt >= CNT_LIMIT)) begin
          state_next = HALT;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end
      TRAP: begin
        handle_trap = 1'b1;
        pc_load     = 1'b1;
        pc_next     = {trap_pc[31:2], 2'b00};
        state_next  = RUN;
      end
      RET: begin
        exit_trap  = 1'b1;
        pc_load    = 1'b1;
        pc_next    = {ret_pc[31:2], 2'b00};
        state_next = RUN;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    // The first DRAIN cycle counts as 1 so the timeout compares against cycles spent waiting.
    if (take_trap) begin
      state_next = mem_busy ? DRAIN : TRAP;
      cnt_next   = mem_busy ? CW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer (DRAIN_TIMEOUT=4, WFI disabled).
module tb_trap_sequencer;

  logic        clk;
  logic        reset;
  logic        exception;
  logic [30:0] exception_cause;
  logic        interrupted;
  logic        mret;
  logic        wfi;
  logic        mem_busy;
  logic [31:0] trap_pc;
  logic [31:0] ret_pc;
  logic        handle_trap;
  logic        exit_trap;
  logic        trap_exception;
  logic [30:0] trap_cause;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  trap_sequencer #(.DRAIN_TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .exception(exception),
    .exception_cause(exception_cause),
    .interrupted(interrupted),
    .mret(mret),
    .wfi(wfi),
    .mem_busy(mem_busy),
    .trap_pc(trap_pc),
    .ret_pc(ret_pc),
    .handle_trap(handle_trap),
    .exit_trap(exit_trap),
    .trap_exception(trap_exception),
    .trap_cause(trap_cause),
    .stall(stall),
    .pc_load(pc_load),
    .pc_next(pc_next),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    exception       = 1'b0;
    exception_cause = '0;
    interrupted     = 1'b0;
    mret            = 1'b0;
    wfi             = 1'b0;
    mem_busy        = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    trap_pc = 32'h0;
    ret_pc  = 32'h0;
    idle_inputs();

    // Reset state
    #12;
    check("rst_handle_trap", 32'(handle_trap), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap_cause", 32'(trap_cause), 32'd0);
    reset = 1'b0;
    tick(1);

    // Exception with idle bus: trap one cycle later, aligned vector
    exception       = 1'b1;
    exception_cause = 31'd2;
    trap_pc         = 32'h8000_0103;
    #1;
    check("exc_stall_comb", 32'(stall), 32'd1);
    tick(1);
    idle_inputs();
    check("exc_handle_trap", 32'(handle_trap), 32'd1);
    check("exc_pc_load", 32'(pc_load), 32'd1);
    check("exc_pc_next", pc_next, 32'h8000_0100);
    check("exc_trap_exception", 32'(trap_exception), 32'd1);
    check("exc_trap_cause", 32'(trap_cause), 32'd2);
    check("exc_exit_trap", 32'(exit_trap), 32'd0);
    tick(1);
    check("exc_back_run_trap", 32'(handle_trap), 32'd0);
    check("exc_back_run_stall", 32'(stall), 32'd0);

    // Interrupt while bus busy for 3 cycles; mret during DRAIN is ignored
    interrupted = 1'b1;
    mem_busy    = 1'b1;
    tick(1);
    interrupted = 1'b0;
    mret        = 1'b1;
    check("irq_drain1_stall", 32'(stall), 32'd1);
    tick(1);
    check("irq_drain2_stall", 32'(stall), 32'd1);
    check("irq_drain2_trap", 32'(handle_trap), 32'd0);
    tick(1);
    mem_busy = 1'b0;
    check("irq_drain3_stall", 32'(stall), 32'd1);
    tick(1);
    mret = 1'b0;
    check("irq_handle_trap", 32'(handle_trap), 32'd1);
    check("irq_trap_exception", 32'(trap_exception), 32'd0);
    check("irq_trap_cause", 32'(trap_cause), 32'd0);
    tick(1);
    check("irq_no_ret_exit", 32'(exit_trap), 32'd0);
    check("irq_no_ret_load", 32'(pc_load), 32'd0);

    // mret with exception: trap wins
    exception       = 1'b1;
    exception_cause = 31'd3;
    mret            = 1'b1;
    trap_pc         = 32'h0000_0100;
    ret_pc          = 32'h0000_0200;
    tick(1);
    idle_inputs();
    check("prio_handle_trap", 32'(handle_trap), 32'd1);
    check("prio_exit_trap", 32'(exit_trap), 32'd0);
    check("prio_pc_next", pc_next, 32'h0000_0100);
    check("prio_cause", 32'(trap_cause), 32'd3);
    tick(1);
    check("prio_after_exit", 32'(exit_trap), 32'd0);

    // mret alone
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("ret_exit_trap", 32'(exit_trap), 32'd1);
    check("ret_pc_load", 32'(pc_load), 32'd1);
    check("ret_pc_next", pc_next, 32'h0000_0200);
    check("ret_handle_trap", 32'(handle_trap), 32'd0);
    tick(1);
    check("ret_exit_drop", 32'(exit_trap), 32'd0);
    check("ret_load_drop", 32'(pc_load), 32'd0);

    // wfi without the WFI build option is a no-op
    wfi = 1'b1;
    #1;
    check("wfi_stall_comb", 32'(stall), 32'd0);
    tick(1);
    check("wfi_still_run", 32'(stall), 32'd0);
    check("wfi_no_load", 32'(pc_load), 32'd0);
    wfi = 1'b0;

    // Drain timeout: 4 DRAIN cycles then HALT, sticky until reset
    exception       = 1'b1;
    exception_cause = 31'd5;
    mem_busy        = 1'b1;
    tick(1);
    exception = 1'b0;
    tick(3);
    check("to_drain4_halted", 32'(halted), 32'd0);
    check("to_drain4_stall", 32'(stall), 32'd1);
    tick(1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_halt_stall", 32'(stall), 32'd1);
    check("to_halt_trap", 32'(handle_trap), 32'd0);
    mem_busy  = 1'b0;
    exception = 1'b1;
    tick(3);
    check("to_halt_sticky", 32'(halted), 32'd1);
    check("to_halt_no_load", 32'(pc_load), 32'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("to_async_clear", 32'(halted), 32'd0);
    check("to_async_cause", 32'(trap_cause), 32'd0);
    check("to_async_stall", 32'(stall), 32'd0);
    #2;
    reset = 1'b0;
    tick(1);

    // Reset during TRAP drops strobes at once; next edge after release acts
    exception       = 1'b1;
    exception_cause = 31'd7;
    trap_pc         = 32'h0000_0440;
    tick(1);
    exception = 1'b0;
    check("rtrap_handle_trap", 32'(handle_trap), 32'd1);
    reset = 1'b1;
    #1;
    check("rtrap_trap_drop", 32'(handle_trap), 32'd0);
    check("rtrap_load_drop", 32'(pc_load), 32'd0);
    check("rtrap_pc_next", pc_next, 32'd0);
    check("rtrap_exception", 32'(trap_exception), 32'd0);
    #2;
    reset           = 1'b0;
    exception       = 1'b1;
    exception_cause = 31'd9;
    tick(1);
    exception = 1'b0;
    check("post_rst_trap", 32'(handle_trap), 32'd1);
    check("post_rst_cause", 32'(trap_cause), 32'd9);
    tick(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
